// File: rtl/prng_pkg.sv
// prng_pkg: shared xorshift16 constants and step function
package prng_pkg;
    localparam int          PRNG_SHIFT_A   = 7;
    localparam int          PRNG_SHIFT_B   = 9;
    localparam int          PRNG_SHIFT_C   = 8;
    localparam logic [15:0] PRNG_ZERO_SEED = 16'hACE1;

    function automatic logic [15:0] xorshift16_step_sh(input logic [15:0] x, input int a, input int b, input int c);
        logic [15:0] t1, t2;
        t1 = x ^ (x << a);
        t2 = t1 ^ (t1 >> b);
        return t2 ^ (t2 << c);
    endfunction

    function automatic logic [15:0] xorshift16_step(input logic [15:0] x);
        return xorshift16_step_sh(x, PRNG_SHIFT_A, PRNG_SHIFT_B, PRNG_SHIFT_C);
    endfunction
endpackage

// File: rtl/xor_prng.sv
// xor_prng: 16-bit xorshift generator, one step per enabled clock
module xor_prng
    import prng_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'h5A3C,
    parameter int          SHIFT_A = PRNG_SHIFT_A,
    parameter int          SHIFT_B = PRNG_SHIFT_B,
    parameter int          SHIFT_C = PRNG_SHIFT_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] rand_num
);
    localparam logic [15:0] SEED_EFF = (SEED != 16'h0) ? SEED : PRNG_ZERO_SEED;

    logic [15:0] r_state;
    logic [15:0] w_next;

    assign w_next   = xorshift16_step_sh(r_state, SHIFT_A, SHIFT_B, SHIFT_C);
    assign rand_num = r_state;

    // state register: async seed load, zero lock-up recovery, enabled advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= SEED_EFF;
        else if (r_state == 16'h0)
            r_state <= SEED_EFF;
        else if (enable)
            r_state <= w_next;
    end
endmodule

// File: tb/tb_xor_prng.sv
// tb_xor_prng: scoreboard bench for xor_prng
`timescale 1ns/1ps
module tb_xor_prng;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] rand_num, rand_zero, rand_c0de;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m;
    bit          seen [0:65535];

    xor_prng u_dut  (.clk(clk), .rst_n(rst_n), .enable(enable), .rand_num(rand_num));
    xor_prng #(.SEED(16'h0))    u_zero (.clk(clk), .rst_n(rst_n), .enable(enable), .rand_num(rand_zero));
    xor_prng #(.SEED(16'hC0DE)) u_c0de (.clk(clk), .rst_n(rst_n), .enable(enable), .rand_num(rand_c0de));

    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] x);
        logic [15:0] t1, t2;
        t1 = x ^ {x[8:0], 7'b0};
        t2 = t1 ^ {9'b0, t1[15:9]};
        return t2 ^ {t2[7:0], 8'b0};
    endfunction

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // monitor: one registered output per clock, compared against the queue
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) chk("scoreboard", rand_num, exp_q.pop_front());
    end

    task automatic cyc(input bit en);
        @(negedge clk);
        enable = en;
        if (en) m = model_step(m);
        exp_q.push_back(m);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        enable = 1'b0;
        #1 chk("async_reset", rand_num, 16'h5A3C);
        @(negedge clk);
        #2 rst_n = 1'b1;
        m = 16'h5A3C;
    endtask

    initial begin
        longint sum_a, sum_b;
        int dups, zeros;
        #1 rst_n = 1'b0;
        #0.02;
        chk("reset_seed", rand_num, 16'h5A3C);
        chk("reset_zero_seed", rand_zero, 16'hACE1);
        chk("reset_c0de", rand_c0de, 16'hC0DE);
        #25;
        chk("reset_held", rand_num, 16'h5A3C);
        @(negedge clk);
        #2 rst_n = 1'b1;
        m = 16'h5A3C;
        cyc(0);
        cyc(0);
        drain();
        chk("hold_after_release", rand_num, 16'h5A3C);
        cyc(1);
        drain();
        chk("first_step", rand_num, 16'h5A1E);
        cyc(1);
        drain();
        chk("second_step", rand_num, 16'h6134);
        for (int i = 0; i < 200; i++) cyc(1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++) cyc(1);
        drain();
        do_reset();
        cyc(1);
        drain();
        chk("restart_first", rand_num, 16'h5A1E);
        cyc(1);
        drain();
        chk("restart_second", rand_num, 16'h6134);
        for (int i = 0; i < 50; i++) cyc(1);
        drain();
        do_reset();
        chk("zero_seed_restart", rand_zero, 16'hACE1);
        sum_a = 0;
        sum_b = 0;
        dups = 0;
        zeros = 0;
        for (int i = 0; i < 65535; i++) begin
            cyc(1);
            if (rand_num == 16'h0) zeros++;
            if (seen[rand_num]) dups++;
            seen[rand_num] = 1'b1;
            if (i < 10000) begin
                sum_a += longint'(rand_num);
                sum_b += longint'(rand_c0de);
            end
        end
        drain();
        chk("period_return", rand_num, 16'h5A3C);
        chk_range("no_repeats", longint'(dups), 0, 0);
        chk_range("never_zero", longint'(zeros), 0, 0);
        chk_range("mean_5a3c", sum_a / 10000, 31000, 34500);
        chk_range("mean_c0de", sum_b / 10000, 31000, 34500);
        chk_range("scoreboard_drained", longint'(exp_q.size()), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_prng.md
Name: xor_prng

Overview:
- 16-bit xorshift pseudo-random number generator for randomised sampling in the ray-tracing pipeline (e.g. jitter, sample selection).
- Produces one new 16-bit value per enabled clock cycle from a registered state seeded at reset.
- Period is 65535: every non-zero 16-bit value appears exactly once per period.
- Not cryptographic.

Parameters:
- SEED, 16'h5A3C, initial state loaded at reset. A value of 0 is illegal and is replaced by 16'hACE1.
- SHIFT_A, 7, first left-shift amount.
- SHIFT_B, 9, right-shift amount.
- SHIFT_C, 8, second left-shift amount.
- Defaults (7,9,8) form the full-period 16-bit xorshift triple. Other values are permitted, but full period is not guaranteed.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance-state strobe, sampled on the rising edge of clk.
- rand_num  out  16  current generator state, registered.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- State register `state[15:0]`; rand_num = state directly, with no combinational logic on the output.
- Reset:
  - rst_n low immediately forces state to SEED_EFF, independent of clk.
  - SEED_EFF = SEED if SEED != 0, else 16'hACE1.
  - rand_num = SEED_EFF throughout reset and until the first enabled edge after release.
- Step function, evaluated sequentially and truncated to 16 bits at each stage:
  - t1 = x ^ (x << SHIFT_A)
  - t2 = t1 ^ (t1 >> SHIFT_B)
  - next = t2 ^ (t2 << SHIFT_C)
  - Shifts are logical; shifted-out bits are discarded and vacated bits are zero.
- On each rising edge with rst_n high:
  - enable = 1: state <= next.
  - enable = 0: state holds.
- Latency: the new value is visible on rand_num one clock after the enabled edge. One value per cycle; no handshake and no ready/valid.
- Zero lock-up guard: if state ever equals 0 (e.g. SEU), the next edge loads SEED_EFF regardless of enable. This is unreachable in normal operation.
- Reset asserted mid-run: state returns to SEED_EFF asynchronously. The sequence restarts identically after release, so output is deterministic and reproducible per SEED.
- Reset release coincident with a clock edge: that edge must not advance the state. The first advance occurs on the first edge on which rst_n is already high.
- Reference sequence with SEED = 16'h5A3C and default shifts: 5A3C, 5A1E, 6134, …
- Statistics: the values are uniform over 1..65535, so the long-run mean is ≈ 32768.

Decomposition:
- Shared package `prng_pkg` holds:
  - the default shift constants;
  - the zero-seed fallback constant 16'hACE1;
  - a pure function `xorshift16_step(logic [15:0] x)` returning next, reusable by other generators and by the bench scoreboard.
- No sub-module; a single always_ff block plus the package function suffices.

Test Plan:
- Reset value: hold rst_n = 0 for 20 ps with SEED = 5A3C -> rand_num = 16'h5A3C during reset; rand_num is unchanged after release until the first enabled edge.
- Known sequence: enable = 1 continuously after reset -> rand_num = 5A1E, then 6134 on successive edges; every value matches `xorshift16_step` of the previous value for 10000 cycles.
- Enable gating: toggle enable pseudo-randomly -> the value holds on every cycle with enable = 0 and advances exactly once per enable = 1 edge.
- Full period: run 65535 enabled cycles -> state returns to SEED; rand_num is never 0; no value repeats within the period.
- Statistics: accumulate 10000 consecutive outputs in a 64-bit sum (SEEDs 5A3C and C0DE) -> average within 31000..34500.
- Reset mid-run and zero seed:
  - Assert rst_n asynchronously between edges -> rand_num = SEED immediately; the sequence after release repeats the first run.
  - Instantiate with SEED = 0 -> reset value is 16'hACE1.
